packet_transmitter: RTL and testbench
=====================================

Name: packet_transmitter

Overview:
- Framed packet sender between the nonce-search core and the UART byte transmitter.
- Sends two packet types:
  - Ping: header, status byte, optional checksum, footer.
  - Nonce: header, NONCE_BYTES payload bytes, optional checksum, footer.
- Generalises the earlier fixed transmitter:
  - parametrised payload length and framing bytes;
  - internal byte counter and nonce snapshot register;
  - optional XOR checksum;
  - registered outputs;
  - configurable ping-while-disabled mode.

Parameters:
- NONCE_BYTES, 16, payload bytes per nonce packet (>=1).
- HEADER_BYTE, 8'd100, first byte of every packet.
- FOOTER_BYTE, 8'd52, last byte of every packet.
- PING_ON_BYTE, 8'd49, ping status byte when chip_enabled_i=1.
- PING_OFF_BYTE, 8'd48, ping status byte when chip_enabled_i=0.
- CHECKSUM_EN, 1, 1 inserts XOR-of-payload byte before the footer.
- PING_WHEN_DISABLED, 1, 1 allows ping packets while chip_enabled_i=0.

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- tx_busy_i  in  1  UART busy; a byte may be issued only when low
- send_nonce_i  in  1  level request: nonce packet pending
- send_ping_i  in  1  level request: ping packet pending
- chip_enabled_i  in  1  chip enable status
- nonce_i  in  NONCE_BYTES*8  nonce value; byte NONCE_BYTES-1 = MSB, sent first
- tx_new_o  out  1  one-cycle pulse: tx_data_o valid for UART
- tx_data_o  out  8  byte to transmit
- ack_nonce_o  out  1  one-cycle pulse when a nonce request is accepted; upstream clears its waiting flag
- ack_ping_o  out  1  one-cycle pulse when a ping request is accepted
- pkt_active_o  out  1  high from acceptance until the cycle after the footer pulse

Behaviour:
- Reset (rst_i=1 at an edge):
  - state=IDLE; all outputs 0; tx_data_o=8'h00; counter, checksum and snapshot cleared.
  - Reset mid-packet aborts the packet with no footer; no ack is regenerated.
- All outputs are registered.
  - tx_new_o and tx_data_o change together; tx_data_o holds its last value between pulses.
- Issue rule:
  - A byte is issued (tx_new_o=1 next cycle) only when tx_busy_i=0 and holdoff=0.
  - holdoff is set for the cycle after every tx_new_o pulse, covering the UART busy-rise latency.
  - While tx_busy_i=1 the FSM holds state; there is no timeout.
- States: IDLE, HEADER_SENT, PAYLOAD, CHECKSUM, FOOTER, DONE.
- IDLE:
  - Nonce is eligible if send_nonce_i=1 and chip_enabled_i=1.
  - Ping is eligible if send_ping_i=1 and (chip_enabled_i=1 or PING_WHEN_DISABLED=1).
  - If both are eligible, nonce wins; the ping stays pending and is serviced by the next packet.
  - On acceptance (issue rule true):
    - emit HEADER_BYTE;
    - pulse the matching ack;
    - latch type;
    - nonce: snapshot nonce_i, counter=NONCE_BYTES-1;
    - checksum=0;
    - go to PAYLOAD.
- PAYLOAD:
  - Ping: emit PING_ON_BYTE or PING_OFF_BYTE, using chip_enabled_i sampled at issue time. One byte only.
  - Nonce: emit snapshot byte[counter]. Counter decrements per byte; after the byte at counter==0, leave PAYLOAD (no wrap).
  - Each payload byte is XORed into the checksum.
  - Next state: CHECKSUM if CHECKSUM_EN=1, else FOOTER.
- CHECKSUM: emit the checksum byte, which covers payload only (header and footer excluded) -> FOOTER.
- FOOTER: emit FOOTER_BYTE -> DONE.
- DONE: one cycle; pkt_active_o drops; -> IDLE. Back-to-back packets are therefore separated by at least one idle cycle.
- Mid-packet changes:
  - chip_enabled_i falling mid-nonce-packet does not abort; the packet completes.
  - Request inputs are ignored outside IDLE.
  - nonce_i changes after acceptance do not affect the packet in flight.
- Counter width: $clog2(NONCE_BYTES), minimum 1.
- Packet length: nonce = NONCE_BYTES+2+CHECKSUM_EN bytes; ping = 3+CHECKSUM_EN bytes.

Decomposition:
- Shared package (skein_link_pkg):
  - state enum;
  - default framing byte constants (HEADER/FOOTER/PING_ON/PING_OFF);
  - packet type enum (PKT_PING, PKT_NONCE).
- Sub-module tx_byte_issuer:
  - owns the holdoff flag, tx_new_o/tx_data_o registers, and the issue-rule evaluation;
  - the FSM supplies byte plus request, and receives an issued strobe.

Test Plan:
- Ping, enabled, NONCE_BYTES=4, CHECKSUM_EN=1, tx_busy_i held 0 except 1 for 5 cycles after each pulse -> bytes 100,49,49,52; ack_ping_o exactly one pulse; no tx_new_o while busy or in the holdoff cycle.
- Nonce 32'hDEADBEEF, NONCE_BYTES=4, CHECKSUM_EN=1 -> 100,DE,AD,BE,EF,22,52 in order (22 = DE^AD^BE^EF); ack_nonce_o one pulse at header issue.
- send_nonce_i and send_ping_i both high, enabled -> full nonce packet, then ping packet 100,49,49,52 after the DONE cycle; each ack pulses once.
- chip_enabled_i=0, both requests high, PING_WHEN_DISABLED=1 -> only ping 100,48,48,52; nonce never acked. With PING_WHEN_DISABLED=0 -> no tx_new_o for 100 cycles.
- Change nonce_i and drop chip_enabled_i after the header of a nonce packet -> original snapshot bytes sent, footer 52 sent.
- Assert rst_i during payload byte 2 -> next cycle all outputs 0, state IDLE. With a pending request afterwards -> fresh packet starting with 100.

Source files
------------

// File: rtl/skein_link_pkg.sv
// rtl/skein_link_pkg.sv - shared types and framing defaults for the packet link
package skein_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER_SENT,
        PAYLOAD,
        CHECKSUM,
        FOOTER,
        DONE
    } tx_state_e;

    typedef enum logic {
        PKT_PING,
        PKT_NONCE
    } pkt_type_e;

    localparam logic [7:0] DEFAULT_HEADER_BYTE   = 8'd100;
    localparam logic [7:0] DEFAULT_FOOTER_BYTE   = 8'd52;
    localparam logic [7:0] DEFAULT_PING_ON_BYTE  = 8'd49;
    localparam logic [7:0] DEFAULT_PING_OFF_BYTE = 8'd48;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tx_byte_issuer.sv
// rtl/tx_byte_issuer.sv - issue-rule gate and registered UART byte strobe
module tx_byte_issuer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_busy_i,
    input  logic       req_i,
    input  logic [7:0] byte_i,
    output logic       issued_o,
    output logic       tx_new_o,
    output logic [7:0] tx_data_o
);

    logic       tx_new_q;
    logic       holdoff_q;
    logic [7:0] tx_data_q;

    // The pulse cycle and the following holdoff cycle both block issue,
    // since the UART raises busy only after it has seen the strobe.
    assign issued_o  = req_i && !tx_busy_i && !tx_new_q && !holdoff_q;
    assign tx_new_o  = tx_new_q;
    assign tx_data_o = tx_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_new_q  <= 1'b0;
            holdoff_q <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            tx_new_q  <= issued_o;
            holdoff_q <= tx_new_q;
            if (issued_o) begin
                tx_data_q <= byte_i;
            end
        end
    end

endmodule

// File: rtl/packet_transmitter.sv
// rtl/packet_transmitter.sv - framed ping/nonce packet sender feeding the UART
module packet_transmitter
    import skein_link_pkg::*;
#(
    parameter int         NONCE_BYTES        = 16,
    parameter logic [7:0] HEADER_BYTE        = DEFAULT_HEADER_BYTE,
    parameter logic [7:0] FOOTER_BYTE        = DEFAULT_FOOTER_BYTE,
    parameter logic [7:0] PING_ON_BYTE       = DEFAULT_PING_ON_BYTE,
    parameter logic [7:0] PING_OFF_BYTE      = DEFAULT_PING_OFF_BYTE,
    parameter bit         CHECKSUM_EN        = 1'b1,
    parameter bit         PING_WHEN_DISABLED = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     tx_busy_i,
    input  logic                     send_nonce_i,
    input  logic                     send_ping_i,
    input  logic                     chip_enabled_i,
    input  logic [NONCE_BYTES*8-1:0] nonce_i,
    output logic                     tx_new_o,
    output logic [7:0]               tx_data_o,
    output logic                     ack_nonce_o,
    output logic                     ack_ping_o,
    output logic                     pkt_active_o
);

    localparam int CW = cnt_width(NONCE_BYTES);

    tx_state_e                   state_q, state_d;
    pkt_type_e                   pkt_q;
    logic [CW-1:0]               cnt_q;
    logic [7:0]                  csum_q;
    logic [NONCE_BYTES-1:0][7:0] snap_q;
    logic                        ack_nonce_q, ack_ping_q, active_q;
    logic                        nonce_ok, ping_ok, last_payload;
    logic                        byte_req, issued;
    logic [7:0]                  byte_val, payload_byte;

    assign nonce_ok     = send_nonce_i && chip_enabled_i;
    assign ping_ok      = send_ping_i && (chip_enabled_i || PING_WHEN_DISABLED);
    assign last_payload = (pkt_q == PKT_PING) || (cnt_q == '0);
    assign payload_byte = (pkt_q == PKT_NONCE) ? snap_q[cnt_q]
                        : (chip_enabled_i ? PING_ON_BYTE : PING_OFF_BYTE);

    assign ack_nonce_o  = ack_nonce_q;
    assign ack_ping_o   = ack_ping_q;
    assign pkt_active_o = active_q;

    tx_byte_issuer u_issuer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .tx_busy_i (tx_busy_i),
        .req_i     (byte_req),
        .byte_i    (byte_val),
        .issued_o  (issued),
        .tx_new_o  (tx_new_o),
        .tx_data_o (tx_data_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pkt_q       <= PKT_PING;
            cnt_q       <= '0;
            csum_q      <= 8'h00;
            snap_q      <= '0;
            ack_nonce_q <= 1'b0;
            ack_ping_q  <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_nonce_q <= 1'b0;
            ack_ping_q  <= 1'b0;
            active_q    <= (state_d != IDLE);
            if (state_q == IDLE && issued) begin
                pkt_q       <= nonce_ok ? PKT_NONCE : PKT_PING;
                ack_nonce_q <= nonce_ok;
                ack_ping_q  <= !nonce_ok;
                csum_q      <= 8'h00;
                if (nonce_ok) begin
                    snap_q <= nonce_i;
                    cnt_q  <= CW'(NONCE_BYTES - 1);
                end
            end
            if (state_q == PAYLOAD && issued) begin
                csum_q <= csum_q ^ byte_val;
                if (!last_payload) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (issued) state_d = PAYLOAD;
            PAYLOAD:  if (issued && last_payload) state_d = CHECKSUM_EN ? CHECKSUM : FOOTER;
            CHECKSUM: if (issued) state_d = FOOTER;
            FOOTER:   if (issued) state_d = DONE;
            DONE:     state_d = IDLE;
            // HEADER_SENT is kept in the encoding but the header goes straight to PAYLOAD
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_req = 1'b0;
        byte_val = 8'h00;
        case (state_q)
            IDLE: begin
                byte_req = nonce_ok || ping_ok;
                byte_val = HEADER_BYTE;
            end
            PAYLOAD: begin
                byte_req = 1'b1;
                byte_val = payload_byte;
            end
            CHECKSUM: begin
                byte_req = 1'b1;
                byte_val = csum_q;
            end
            FOOTER: begin
                byte_req = 1'b1;
                byte_val = FOOTER_BYTE;
            end
            default: begin
                byte_req = 1'b0;
                byte_val = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_packet_transmitter.sv
// tb/tb_packet_transmitter.sv - directed self-checking bench for packet_transmitter
module tb_packet_transmitter;
    import skein_link_pkg::*;

    logic        clk;
    logic        rst;
    logic        tx_busy;
    logic        send_nonce;
    logic        send_ping;
    logic        chip_en;
    logic [31:0] nonce;

    logic        tx_new_a, ack_n_a, ack_p_a, act_a;
    logic [7:0]  tx_data_a;
    logic        tx_new_b, ack_n_b, ack_p_b, act_b;
    logic [7:0]  tx_data_b;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  a_bytes[$];
    logic [7:0]  exp_q[$];
    int          cnt_ack_n = 0;
    int          cnt_ack_p = 0;
    int          b_pulses  = 0;
    int          issue_viol = 0;
    int          busy_left = 0;
    logic        prev1 = 1'b0;
    logic        prev2 = 1'b0;

    packet_transmitter #(
        .NONCE_BYTES(4), .CHECKSUM_EN(1'b1), .PING_WHEN_DISABLED(1'b1)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .tx_busy_i(tx_busy),
        .send_nonce_i(send_nonce), .send_ping_i(send_ping),
        .chip_enabled_i(chip_en), .nonce_i(nonce),
        .tx_new_o(tx_new_a), .tx_data_o(tx_data_a),
        .ack_nonce_o(ack_n_a), .ack_ping_o(ack_p_a), .pkt_active_o(act_a)
    );

    packet_transmitter #(
        .NONCE_BYTES(4), .CHECKSUM_EN(1'b1), .PING_WHEN_DISABLED(1'b0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .tx_busy_i(tx_busy),
        .send_nonce_i(send_nonce), .send_ping_i(send_ping),
        .chip_enabled_i(chip_en), .nonce_i(nonce),
        .tx_new_o(tx_new_b), .tx_data_o(tx_data_b),
        .ack_nonce_o(ack_n_b), .ack_ping_o(ack_p_b), .pkt_active_o(act_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // UART model and byte monitor: busy for 5 cycles after each strobe
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_new_a) begin
                a_bytes.push_back(tx_data_a);
                if (tx_busy || prev1 || prev2) issue_viol++;
            end
            if (ack_n_a) cnt_ack_n++;
            if (ack_p_a) cnt_ack_p++;
            if (tx_new_b) b_pulses++;
            prev2 = prev1;
            prev1 = tx_new_a;
            if (tx_new_a) busy_left = 5;
            else if (busy_left > 0) busy_left--;
            tx_busy = (busy_left > 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        a_bytes.delete();
        cnt_ack_n = 0;
        cnt_ack_p = 0;
        b_pulses  = 0;
    endtask

    task automatic wait_ack(input string tag, input bit want_nonce);
        int n = 0;
        while (!(want_nonce ? ack_n_a : ack_p_a) && n < 500) begin
            tick();
            n++;
        end
        check(tag, 32'(want_nonce ? ack_n_a : ack_p_a), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (act_a && n < 500) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check(tag, 32'(act_a), 32'd0);
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_len"}, 32'(a_bytes.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < a_bytes.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), 32'(a_bytes[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        rst = 1'b1;
        send_nonce = 1'b0;
        send_ping = 1'b0;
        chip_en = 1'b1;
        nonce = 32'h0;
        repeat (3) tick();
        check("rst_tx_new", 32'(tx_new_a), 32'd0);
        check("rst_tx_data", 32'(tx_data_a), 32'd0);
        check("rst_acks", 32'({ack_n_a, ack_p_a}), 32'd0);
        check("rst_active", 32'(act_a), 32'd0);
        check("rst_state", 32'(dut_a.state_q), 32'(IDLE));
        rst = 1'b0;
        repeat (2) tick();

        // Ping while enabled
        clear_log();
        send_ping = 1'b1;
        wait_ack("ping_ack", 1'b0);
        check("ping_hdr_strobe", 32'({tx_new_a, tx_data_a}), 32'h164);
        check("ping_active", 32'(act_a), 32'd1);
        send_ping = 1'b0;
        wait_done("ping_done");
        exp_q = {8'd100, 8'd49, 8'd49, 8'd52};
        check_bytes("ping");
        check("ping_ack_cnt", 32'(cnt_ack_p), 32'd1);
        check("ping_nack_cnt", 32'(cnt_ack_n), 32'd0);

        // Nonce DEADBEEF
        clear_log();
        nonce = 32'hDEADBEEF;
        send_nonce = 1'b1;
        wait_ack("nonce_ack", 1'b1);
        check("nonce_hdr_strobe", 32'({tx_new_a, tx_data_a}), 32'h164);
        send_nonce = 1'b0;
        wait_done("nonce_done");
        exp_q = {8'd100, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22, 8'd52};
        check_bytes("nonce");
        check("nonce_ack_cnt", 32'(cnt_ack_n), 32'd1);

        // Both requests: nonce first, ping afterwards
        clear_log();
        nonce = 32'h01020304;
        send_nonce = 1'b1;
        send_ping = 1'b1;
        wait_ack("both_nack", 1'b1);
        send_nonce = 1'b0;
        wait_ack("both_pack", 1'b0);
        send_ping = 1'b0;
        wait_done("both_done");
        exp_q = {8'd100, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'd52,
                 8'd100, 8'd49, 8'd49, 8'd52};
        check_bytes("both");
        check("both_ack_n", 32'(cnt_ack_n), 32'd1);
        check("both_ack_p", 32'(cnt_ack_p), 32'd1);

        // Chip disabled: only ping on dut_a, nothing on dut_b
        clear_log();
        chip_en = 1'b0;
        send_nonce = 1'b1;
        send_ping = 1'b1;
        wait_ack("dis_pack", 1'b0);
        send_ping = 1'b0;
        wait_done("dis_done");
        repeat (100) tick();
        exp_q = {8'd100, 8'd48, 8'd48, 8'd52};
        check_bytes("dis");
        check("dis_ack_n", 32'(cnt_ack_n), 32'd0);
        check("dis_b_quiet", 32'(b_pulses), 32'd0);
        send_nonce = 1'b0;

        // Nonce and enable change after acceptance
        clear_log();
        chip_en = 1'b1;
        nonce = 32'hA1B2C3D4;
        send_nonce = 1'b1;
        wait_ack("mid_ack", 1'b1);
        nonce = 32'hFFFFFFFF;
        chip_en = 1'b0;
        send_nonce = 1'b0;
        wait_done("mid_done");
        exp_q = {8'd100, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h04, 8'd52};
        check_bytes("mid");

        // Reset during the payload
        clear_log();
        chip_en = 1'b1;
        nonce = 32'h11223344;
        send_nonce = 1'b1;
        wait_ack("rstp_ack", 1'b1);
        send_nonce = 1'b0;
        for (int n = 0; n < 200 && a_bytes.size() < 3; n++) tick();
        check("rstp_reached", 32'(a_bytes.size()), 32'd3);
        rst = 1'b1;
        tick();
        check("rstp_tx_new", 32'(tx_new_a), 32'd0);
        check("rstp_tx_data", 32'(tx_data_a), 32'd0);
        check("rstp_acks", 32'({ack_n_a, ack_p_a}), 32'd0);
        check("rstp_active", 32'(act_a), 32'd0);
        check("rstp_state", 32'(dut_a.state_q), 32'(IDLE));
        rst = 1'b0;
        repeat (30) tick();
        check("rstp_no_footer", 32'(a_bytes.size()), 32'd3);
        check("rstp_no_reack", 32'(cnt_ack_n), 32'd1);

        clear_log();
        send_ping = 1'b1;
        wait_ack("post_ack", 1'b0);
        send_ping = 1'b0;
        wait_done("post_done");
        exp_q = {8'd100, 8'd49, 8'd49, 8'd52};
        check_bytes("post");

        check("issue_rule", 32'(issue_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
